// File: rtl/fft_seq_pkg.sv
// Shared types and constants for the FFT frame sequencer.
// Holds the per-bank state encoding, the input FSM encoding, the shortest
// legal frame length (log2) and the width of the status counters.
package fft_seq_pkg;

   typedef enum logic [2:0] {
      B_FREE,
      B_FILL,
      B_FULL,
      B_BUSY,
      B_DONE
   } bank_state_t;

   typedef enum logic [1:0] {
      IN_IDLE,
      IN_FILL,
      IN_WAIT
   } in_state_t;

   localparam int MIN_FFT_N = 2;
   localparam int CNT_W     = 16;

endpackage

// File: rtl/fft_seq_bitrev_counter.sv
// Sample counter with a bit-reversed view over a runtime length of len_n bits.
// Latency: iter/last are combinational from the count; count updates on the clock edge.
// Backpressure: none; advances only when inc is high, wraps to 0 after the last sample.
// Ports: clk, rst (sync, active-high), clr (restart at 0), inc (count one sample),
//        len_n (log2 frame length), iter (bit-reversed count, zero-extended), last.
module fft_seq_bitrev_counter
   import fft_seq_pkg::*;
#(
   parameter int MAX_N = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [3:0]       len_n,
   output logic [MAX_N-1:0] iter,
   output logic             last
);

   logic [MAX_N-1:0] cnt;
   logic [MAX_N-1:0] rev;
   logic [MAX_N:0]   cnt_p1;

   // Reversing all MAX_N bits puts the live low bits at the top; shifting down
   // by (MAX_N - len_n) leaves the len_n-bit reversal with zeros above it.
   assign rev    = {<<{cnt}};
   assign iter   = rev >> (4'(MAX_N) - len_n);

   // One extra bit so the full-length frame does not overflow the compare.
   assign cnt_p1 = {1'b0, cnt} + (MAX_N+1)'(1);
   assign last   = (cnt_p1 >> len_n) == (MAX_N+1)'(1);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= last ? '0 : cnt_p1[MAX_N-1:0];
      end
   end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Double-buffered frame sequencer: fills two RAM banks in bit-reversed order and
// hands full banks to an FFT engine. Writes are same-cycle; eng_start and frame_done
// are registered one cycle after the triggering event. Backpressure via in_ready;
// with FFT_SEQ_DROP_EN defined, in_ready stays high and unfillable samples are dropped.
// Ports: cfg_fft_n/autorun/run/fin control; in_* sample stream; wact/wbank/wa/wdw RAM
//        write port; eng_* engine handshake; frame_done/done_bank/drop_cnt status.
module fft_frame_sequencer
   import fft_seq_pkg::*;
#(
   parameter int MAX_FFT_N = 10,
   parameter int FFT_DW    = 16,
   parameter int BW_W      = $clog2(FFT_DW) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [3:0]               cfg_fft_n,
   input  logic                     autorun,
   input  logic                     run,
   input  logic                     fin,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [FFT_DW-1:0] in_real,
   input  logic signed [FFT_DW-1:0] in_imag,
   output logic                     wact,
   output logic                     wbank,
   output logic [MAX_FFT_N-1:0]     wa,
   output logic [2*FFT_DW-1:0]      wdw,
   output logic                     eng_start,
   output logic                     eng_bank,
   output logic [3:0]               eng_len_n,
   output logic [BW_W-1:0]          eng_bfp_bw,
   input  logic                     eng_done,
   output logic                     frame_done,
   output logic                     done_bank,
   output logic [15:0]              drop_cnt
);

   localparam logic [3:0] MAX_N4 = 4'(MAX_FFT_N);
   localparam logic [3:0] MIN_N4 = 4'(MIN_FFT_N);

   bank_state_t      bank_st  [2];
   logic [3:0]       bank_len [2];
   logic [BW_W-1:0]  bank_bw  [2];
   in_state_t        in_st;

   logic             fill_bank, fill_first, older, eng_busy;
   logic [3:0]       eff_n, len_use;
   logic             accept, cnt_clr, cnt_last;
   logic [MAX_FFT_N-1:0] cnt_iter;
   logic [BW_W-1:0]  bw_re, bw_im, samp_bw, bw_new;
   logic [1:0]       is_full, is_done, free_now;
   logic             fin_rel, rel_bank, dispatch, disp_bank, done_ok, new_bank;

   // Significant bits of a two's-complement value: one above the highest bit
   // that differs from the sign bit; 0 and -1 need just the sign bit.
   function automatic logic [BW_W-1:0] comp_bw(input logic [FFT_DW-1:0] x);
      logic [BW_W-1:0] r;
      r = BW_W'(1);
      for (int i = 0; i < FFT_DW - 1; i++) begin
         if (x[i] != x[FFT_DW-1]) r = BW_W'(i + 2);
      end
      return r;
   endfunction

   assign eff_n   = (cfg_fft_n < MIN_N4 || cfg_fft_n > MAX_N4) ? MAX_N4 : cfg_fft_n;
   // Length is captured on the first sample; later cfg changes are ignored.
   assign len_use = fill_first ? eff_n : bank_len[fill_bank];

   assign bw_re   = comp_bw(in_real);
   assign bw_im   = comp_bw(in_imag);
   assign samp_bw = (bw_re > bw_im) ? bw_re : bw_im;
   assign bw_new  = (samp_bw > bank_bw[fill_bank]) ? samp_bw : bank_bw[fill_bank];

   assign is_full  = {bank_st[1] == B_FULL, bank_st[0] == B_FULL};
   assign is_done  = {bank_st[1] == B_DONE, bank_st[0] == B_DONE};
   // 'older' names the bank that completed its fill first; it breaks ties when
   // both banks are FULL or both DONE.
   assign fin_rel   = fin && (|is_done);
   assign rel_bank  = (&is_done) ? older : is_done[1];
   // A bank being released this cycle counts as free so the input side can
   // claim it without waiting for the state register to show FREE.
   assign free_now  = {bank_st[1] == B_FREE || (fin_rel && rel_bank),
                       bank_st[0] == B_FREE || (fin_rel && !rel_bank)};
   assign new_bank  = !free_now[0];
   assign dispatch  = !eng_busy && (|is_full) && (autorun || run);
   assign disp_bank = (&is_full) ? older : is_full[1];
   assign done_ok   = eng_done && eng_busy && (bank_st[eng_bank] == B_BUSY);

`ifdef FFT_SEQ_DROP_EN
   logic [15:0] drop_r;
   assign in_ready = !rst;
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_r <= '0;
      end else if (in_valid && in_st != IN_FILL && drop_r != 16'hFFFF) begin
         drop_r <= drop_r + 16'd1;
      end
   end
   assign drop_cnt = drop_r;
`else
   assign in_ready = !rst && (in_st == IN_FILL);
   assign drop_cnt = '0;
`endif

   assign accept  = in_valid && in_ready && (in_st == IN_FILL);
   assign cnt_clr = (in_st == IN_IDLE) && (|free_now);

   assign wact  = accept;
   assign wbank = accept && fill_bank;
   assign wa    = accept ? cnt_iter : '0;
   assign wdw   = accept ? {in_imag, in_real} : '0;

   fft_seq_bitrev_counter #(.MAX_N(MAX_FFT_N)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (accept),
      .len_n (len_use),
      .iter  (cnt_iter),
      .last  (cnt_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         in_st       <= IN_IDLE;
         bank_st[0]  <= B_FREE;
         bank_st[1]  <= B_FREE;
         bank_len[0] <= '0;
         bank_len[1] <= '0;
         bank_bw[0]  <= '0;
         bank_bw[1]  <= '0;
         fill_bank   <= 1'b0;
         fill_first  <= 1'b0;
         older       <= 1'b0;
         eng_busy    <= 1'b0;
         eng_start   <= 1'b0;
         eng_bank    <= 1'b0;
         eng_len_n   <= '0;
         eng_bfp_bw  <= '0;
         frame_done  <= 1'b0;
         done_bank   <= 1'b0;
      end else begin
         eng_start  <= 1'b0;
         frame_done <= 1'b0;

         if (fin_rel) bank_st[rel_bank] <= B_FREE;

         if (done_ok) begin
            bank_st[eng_bank] <= B_DONE;
            eng_busy          <= 1'b0;
            frame_done        <= 1'b1;
            done_bank         <= eng_bank;
         end

         if (dispatch) begin
            bank_st[disp_bank] <= B_BUSY;
            eng_busy           <= 1'b1;
            eng_start          <= 1'b1;
            eng_bank           <= disp_bank;
            eng_len_n          <= bank_len[disp_bank];
            eng_bfp_bw         <= bank_bw[disp_bank];
         end

         case (in_st)
            IN_IDLE: begin
               if (|free_now) begin
                  in_st             <= IN_FILL;
                  fill_bank         <= new_bank;
                  fill_first        <= 1'b1;
                  bank_st[new_bank] <= B_FILL;
                  bank_bw[new_bank] <= '0;
               end else begin
                  in_st <= IN_WAIT;
               end
            end
            IN_FILL: begin
               if (accept) begin
                  fill_first          <= 1'b0;
                  bank_len[fill_bank] <= len_use;
                  bank_bw[fill_bank]  <= bw_new;
                  if (cnt_last) begin
                     bank_st[fill_bank] <= B_FULL;
                     in_st              <= IN_IDLE;
                     older <= (bank_st[~fill_bank] inside {B_FULL, B_BUSY, B_DONE})
                              ? ~fill_bank : fill_bank;
                  end
               end
            end
            IN_WAIT: begin
               if (|free_now) in_st <= IN_IDLE;
            end
            default: in_st <= IN_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: table of frames (length, samples, expected
// engine fields) plus hand-written sequences for manual run, both banks DONE,
// fin/eng_done collision and reset during an FFT. Writes go through a scoreboard.
module tb_fft_frame_sequencer;

   logic              clk, rst;
   logic [3:0]        cfg_fft_n;
   logic              autorun, run, fin;
   logic              in_valid, in_ready;
   logic signed [15:0] in_real, in_imag;
   logic              wact, wbank;
   logic [9:0]        wa;
   logic [31:0]       wdw;
   logic              eng_start, eng_bank;
   logic [3:0]        eng_len_n;
   logic [4:0]        eng_bfp_bw;
   logic              eng_done, frame_done, done_bank;
   logic [15:0]       drop_cnt;

   fft_frame_sequencer dut (
      .clk(clk), .rst(rst), .cfg_fft_n(cfg_fft_n), .autorun(autorun), .run(run), .fin(fin),
      .in_valid(in_valid), .in_ready(in_ready), .in_real(in_real), .in_imag(in_imag),
      .wact(wact), .wbank(wbank), .wa(wa), .wdw(wdw),
      .eng_start(eng_start), .eng_bank(eng_bank), .eng_len_n(eng_len_n),
      .eng_bfp_bw(eng_bfp_bw), .eng_done(eng_done),
      .frame_done(frame_done), .done_bank(done_bank), .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int start_cnt = 0;
   int fd_cnt = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [3:0]        cfg;
      int                len;
      logic signed [15:0] re [4];
      logic signed [15:0] im [4];
      int                bw;
   } vec_t;
   vec_t vt [6];

   typedef struct {
      logic [9:0]  wa;
      logic [31:0] wdw;
      logic        wbank;
   } wr_t;
   wr_t sbq [$];
   wr_t mon_e;

   function automatic logic [9:0] brev(input int i, input int len);
      logic [9:0] iv, r;
      iv = 10'(i);
      r  = '0;
      for (int k = 0; k < len; k++) r[len-1-k] = iv[k];
      return r;
   endfunction

   // Write-port monitor: every write must match the oldest expected sample.
   always @(negedge clk) begin
      #2;
      if (wact) begin
         if (sbq.size() == 0) begin
            chk("unexpected_write", 1, 0);
         end else begin
            mon_e = sbq.pop_front();
            chk("wa", wa, mon_e.wa);
            chk("wdw", wdw, mon_e.wdw);
            chk("wbank", wbank, mon_e.wbank);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (eng_start)  start_cnt++;
      if (frame_done) fd_cnt++;
   end

   task automatic set_vec(input int idx, input logic [3:0] cfg, input int len,
                          input int r0, input int r1, input int r2, input int r3,
                          input int i0, input int i1, input int i2, input int i3,
                          input int bw);
      vt[idx].cfg = cfg;  vt[idx].len = len;  vt[idx].bw = bw;
      vt[idx].re[0] = 16'(r0); vt[idx].re[1] = 16'(r1);
      vt[idx].re[2] = 16'(r2); vt[idx].re[3] = 16'(r3);
      vt[idx].im[0] = 16'(i0); vt[idx].im[1] = 16'(i1);
      vt[idx].im[2] = 16'(i2); vt[idx].im[3] = 16'(i3);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; run = 1'b0; fin = 1'b0; eng_done = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_eng_bank", eng_bank, 0);
      chk("rst_eng_len_n", eng_len_n, 0);
      chk("rst_eng_bfp_bw", eng_bfp_bw, 0);
      chk("rst_done_bank", done_bank, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      chk("rst_wact", wact, 0);
      rst = 1'b0;
      sbq.delete();
   endtask

   // Streams one frame from table entry vi; the sample is held until written.
   task automatic send_frame(input int vi, input logic exp_bank);
      int i, stall, n, len;
      logic signed [15:0] re, im;
      len = vt[vi].len;
      n = 1 << len;
      i = 0; stall = 0;
      @(negedge clk);
      cfg_fft_n = vt[vi].cfg;
      while (i < n && stall < 5000) begin
         // Disturb the config once the frame is under way; it must be ignored.
         if (i == 1) cfg_fft_n = vt[vi].cfg ^ 4'h5;
         re = vt[vi].re[i % 4];
         im = vt[vi].im[i % 4];
         in_valid = 1'b1; in_real = re; in_imag = im;
         #1;
         if (wact) begin
            sbq.push_back('{brev(i, len), {im, re}, exp_bank});
            i++;
         end else begin
            stall++;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("frame_accept_timeout", (stall >= 5000) ? 1 : 0, 0);
   endtask

   task automatic expect_start(input int eb, input int el, input int ebw);
      int k;
      bit seen;
      seen = 1'b0;
      for (k = 0; k < 200; k++) begin
         @(negedge clk);
         if (eng_start) begin seen = 1'b1; break; end
      end
      chk("eng_start_seen", seen, 1);
      if (seen) begin
         chk("start_latency", k, 0);
         chk("eng_bank", eng_bank, eb);
         chk("eng_len_n", eng_len_n, el);
         chk("eng_bfp_bw", eng_bfp_bw, ebw);
         @(negedge clk);
         chk("eng_start_pulse", eng_start, 0);
      end
   endtask

   task automatic engine_done(input int eb);
      int k;
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      eng_done = 1'b1;
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         eng_done = 1'b0;
         if (frame_done) begin seen = 1'b1; break; end
      end
      chk("frame_done_seen", seen, 1);
      if (seen) begin
         chk("done_bank", done_bank, eb);
         @(negedge clk);
         chk("frame_done_pulse", frame_done, 0);
      end
   endtask

   task automatic fin_pulse();
      @(negedge clk); fin = 1'b1;
      @(negedge clk); fin = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int sc, fc;
      int d0;
      rst = 1'b1; cfg_fft_n = 4'd3; autorun = 1'b1; run = 1'b0; fin = 1'b0;
      in_valid = 1'b0; in_real = '0; in_imag = '0; eng_done = 1'b0;
      d0 = 0;

      //       idx cfg    L   re0   re1    re2    re3   im0 im1 im2 im3 bw
      set_vec(0, 4'd3,  3,  1,    2,     3,     4,    0,  0,  0,  0,  4);
      set_vec(1, 4'd2,  2,  3,    -100,  32767, 0,    0,  0,  0,  0,  16);
      set_vec(2, 4'd2,  2,  1,    -2,    3,     0,    0,  0,  0,  0,  3);
      set_vec(3, 4'd15, 10, 0,    -1,    0,     -1,   5,  0,  0,  0,  4);
      set_vec(4, 4'd4,  4,  -8,   7,     0,     0,    0,  0,  -9, 0,  5);
      set_vec(5, 4'd1,  10, 2,    0,     0,     0,    0,  0,  0,  -1, 3);

      do_reset();

      // Table: each frame is filled, dispatched, completed and released;
      // banks alternate because the next fill starts while the FFT runs.
      for (int vi = 0; vi < 6; vi++) begin
         send_frame(vi, 1'(vi % 2));
         expect_start(vi % 2, vt[vi].len, vt[vi].bw);
         engine_done(vi % 2);
         fin_pulse();
      end
      chk("table_sb_empty", sbq.size(), 0);

      // Manual dispatch: autorun off leaves the bank FULL until run.
      do_reset();
      autorun = 1'b0;
      fin_pulse();
      send_frame(1, 1'b0);
      sc = start_cnt;
      repeat (10) @(negedge clk);
      chk("manual_no_start", start_cnt - sc, 0);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      chk("manual_eng_start", eng_start, 1);
      chk("manual_eng_bank", eng_bank, 0);
      chk("manual_eng_bfp_bw", eng_bfp_bw, 16);
      engine_done(0);
      fin_pulse();
      autorun = 1'b1;

      // Both banks DONE with the stream still arriving.
      do_reset();
      send_frame(2, 1'b0);
      expect_start(0, 2, 3);
      engine_done(0);
      send_frame(1, 1'b1);
      expect_start(1, 2, 16);
      engine_done(1);
      @(negedge clk);
      d0 = drop_cnt;
      in_valid = 1'b1; in_real = 16'sd9; in_imag = 16'sd0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
`ifdef FFT_SEQ_DROP_EN
         chk("wait_in_ready", in_ready, 1);
`else
         chk("wait_in_ready", in_ready, 0);
`endif
      end
      in_valid = 1'b0;
`ifdef FFT_SEQ_DROP_EN
      chk("drop_cnt_delta", drop_cnt - d0, 10);
`else
      chk("drop_cnt_tied", drop_cnt, 0);
`endif
      fin_pulse();
      send_frame(0, 1'b0);
      expect_start(0, 3, 4);

      // fin and eng_done together: bank 1 freed, bank 0 completes.
      @(negedge clk);
      fin = 1'b1; eng_done = 1'b1;
      @(negedge clk);
      fin = 1'b0; eng_done = 1'b0;
      chk("collide_frame_done", frame_done, 1);
      chk("collide_done_bank", done_bank, 0);
      send_frame(2, 1'b1);
      expect_start(1, 2, 3);
      engine_done(1);

      // Reset while the engine is busy abandons the frame.
      do_reset();
      send_frame(2, 1'b0);
      expect_start(0, 2, 3);
      @(negedge clk);
      do_reset();
      fc = fd_cnt;
      @(negedge clk); eng_done = 1'b1;
      @(negedge clk); eng_done = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_busy_no_frame_done", fd_cnt - fc, 0);
      send_frame(2, 1'b0);
      expect_start(0, 2, 3);
      send_frame(1, 1'b1);
      repeat (5) @(negedge clk);
      chk("final_sb_empty", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
